// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache request controller.
// - ctrl_state_t : controller FSM state encoding
// - DEF_NREQ, DEF_MISS_LATENCY : default build parameters
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        STALL,
        REPLAY,
        RESP
    } ctrl_state_t;

    localparam int unsigned DEF_NREQ         = 2;
    localparam int unsigned DEF_MISS_LATENCY = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i        : request vector, one bit per requester
//   last_grant_i : index of the most recent winner; search starts one above it
//   enable_i     : when low no grant is produced
//   grant_o      : one-hot grant
//   grant_idx_o  : encoded index of the granted requester
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    input  logic             enable_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    always_comb begin
        logic found;
        int   idx;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        if (enable_i) begin
            // Offsets 1..NREQ so the last winner is considered last.
            for (int off = 1; off <= int'(NREQ); off++) begin
                idx = (int'(last_grant_i) + off) % int'(NREQ);
                if (!found && req_i[idx]) begin
                    found        = 1'b1;
                    grant_o[idx] = 1'b1;
                    grant_idx_o  = IDX_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/cache_req_ctrl.sv
// Request controller in front of a 2-way, 16-set single-word cache.
// Arbitrates NREQ requesters round-robin, issues one cache access at a time,
// models miss latency with a stall counter and replays read misses so they
// return filled data. Keeps hit/miss statistics.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_valid_i/we_i     : per-requester valid and write flag
//   req_addr_i/wdata_i   : flattened 32-bit address / write data per requester
//   req_ready_o          : one-hot accept pulse (combinational in IDLE)
//   rsp_valid_o          : one-hot response pulse to the granted requester
//   rsp_rdata_o          : read data (0 for writes), rsp_hit_o: first-lookup result
//   busy_o               : controller not in IDLE
//   hit_count_o/miss_count_o : wrapping statistics counters
//   c_*                  : cache master interface
module cache_req_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned NREQ         = DEF_NREQ,
    parameter int unsigned MISS_LATENCY = DEF_MISS_LATENCY
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*32-1:0]   req_addr_i,
    input  logic [NREQ*32-1:0]   req_wdata_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_hit_o,
    output logic                 busy_o,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o,
    output logic                 c_read_en_o,
    output logic                 c_write_en_o,
    output logic [31:0]          c_address_o,
    output logic [31:0]          c_write_data_o,
    input  logic [31:0]          c_read_data_i,
    input  logic                 c_hit_i
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = $clog2(MISS_LATENCY + 1);
    localparam logic [CntW-1:0] CntLoad  = CntW'(MISS_LATENCY - 1);
    localparam logic [IdxW-1:0] LastInit = IdxW'(NREQ - 1);

    ctrl_state_t     state_q;
    logic [IdxW-1:0] last_grant_q;
    logic            we_q;
    logic            hit_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     hit_count_q;
    logic [31:0]     miss_count_q;
    logic            c_read_en_q;
    logic            c_write_en_q;
    logic [31:0]     c_address_q;
    logic [31:0]     c_write_data_q;

    logic [NREQ-1:0] grant;
    logic [IdxW-1:0] grant_idx;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IdxW)
    ) u_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == IDLE),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // The latched address/data live directly in the cache-facing registers,
    // so REPLAY reuses them without a second copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            last_grant_q   <= LastInit;
            we_q           <= 1'b0;
            hit_q          <= 1'b0;
            cnt_q          <= '0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
            c_read_en_q    <= 1'b0;
            c_write_en_q   <= 1'b0;
            c_address_q    <= '0;
            c_write_data_q <= '0;
        end else begin
            c_read_en_q  <= 1'b0;
            c_write_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        we_q           <= req_we_i[grant_idx];
                        c_address_q    <= req_addr_i[32*int'(grant_idx) +: 32];
                        c_write_data_q <= req_wdata_i[32*int'(grant_idx) +: 32];
                        c_read_en_q    <= !req_we_i[grant_idx];
                        c_write_en_q   <= req_we_i[grant_idx];
                        last_grant_q   <= grant_idx;
                        state_q        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= c_hit_i;
                    if (c_hit_i) begin
                        hit_count_q <= hit_count_q + 32'd1;
                        state_q     <= RESP;
                    end else begin
                        miss_count_q <= miss_count_q + 32'd1;
                        cnt_q        <= CntLoad;
                        state_q      <= STALL;
                    end
                end
                STALL: begin
                    if (cnt_q == '0) begin
                        if (we_q) begin
                            state_q <= RESP;
                        end else begin
                            c_read_en_q <= 1'b1;
                            state_q     <= REPLAY;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                REPLAY: state_q <= RESP;
                RESP:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response fields are a pure decode of RESP; read data comes straight from
    // the cache's registered output, which is valid during RESP.
    always_comb begin
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_hit_o   = 1'b0;
        if (state_q == RESP) begin
            rsp_valid_o[last_grant_q] = 1'b1;
            rsp_hit_o                 = hit_q;
            if (!we_q) begin
                rsp_rdata_o = c_read_data_i;
            end
        end
    end

    assign req_ready_o    = grant;
    assign busy_o         = (state_q != IDLE);
    assign hit_count_o    = hit_count_q;
    assign miss_count_o   = miss_count_q;
    assign c_read_en_o    = c_read_en_q;
    assign c_write_en_o   = c_write_en_q;
    assign c_address_o    = c_address_q;
    assign c_write_data_o = c_write_data_q;

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl: instance 0 uses MISS_LATENCY=4,
// instance 1 uses MISS_LATENCY=1. Each has its own 2-way, 16-set cache model
// that fills from a memory whose content at every address equals the address.
module tb_cache_req_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0][1:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [1:0][63:0] req_addr, req_wdata;
    logic [1:0][31:0] rsp_rdata, hit_cnt, miss_cnt, m_addr, m_wdata, m_rdata;
    logic [1:0]       rsp_hit, busy, m_re, m_we, m_hit;

    int n_pass  = 0;
    int n_total = 0;

    cache_req_ctrl #(.NREQ(2), .MISS_LATENCY(4)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .req_ready_o(req_ready[0]), .rsp_valid_o(rsp_valid[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_hit_o(rsp_hit[0]), .busy_o(busy[0]),
        .hit_count_o(hit_cnt[0]), .miss_count_o(miss_cnt[0]),
        .c_read_en_o(m_re[0]), .c_write_en_o(m_we[0]),
        .c_address_o(m_addr[0]), .c_write_data_o(m_wdata[0]),
        .c_read_data_i(m_rdata[0]), .c_hit_i(m_hit[0])
    );

    cache_req_ctrl #(.NREQ(2), .MISS_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .req_ready_o(req_ready[1]), .rsp_valid_o(rsp_valid[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_hit_o(rsp_hit[1]), .busy_o(busy[1]),
        .hit_count_o(hit_cnt[1]), .miss_count_o(miss_cnt[1]),
        .c_read_en_o(m_re[1]), .c_write_en_o(m_we[1]),
        .c_address_o(m_addr[1]), .c_write_data_o(m_wdata[1]),
        .c_read_data_i(m_rdata[1]), .c_hit_i(m_hit[1])
    );

    // Cache model: set = addr[5:2], tag = addr[31:6], write-allocate.
    bit [25:0] tag_m [2][16][2];
    bit        val_m [2][16][2];
    bit [31:0] dat_m [2][16][2];
    bit        lru_m [2][16];

    always_comb begin
        m_hit = '0;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 2; w++)
                if (val_m[k][m_addr[k][5:2]][w] && tag_m[k][m_addr[k][5:2]][w] == m_addr[k][31:6])
                    m_hit[k] = 1'b1;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_re[k] || m_we[k]) begin
                if (m_hit[k]) begin
                    for (int w = 0; w < 2; w++) begin
                        if (val_m[k][m_addr[k][5:2]][w] &&
                            tag_m[k][m_addr[k][5:2]][w] == m_addr[k][31:6]) begin
                            if (m_we[k]) dat_m[k][m_addr[k][5:2]][w] <= m_wdata[k];
                            m_rdata[k] <= m_we[k] ? m_wdata[k] : dat_m[k][m_addr[k][5:2]][w];
                            lru_m[k][m_addr[k][5:2]] <= (w == 0);
                        end
                    end
                end else begin
                    val_m[k][m_addr[k][5:2]][lru_m[k][m_addr[k][5:2]]] <= 1'b1;
                    tag_m[k][m_addr[k][5:2]][lru_m[k][m_addr[k][5:2]]] <= m_addr[k][31:6];
                    dat_m[k][m_addr[k][5:2]][lru_m[k][m_addr[k][5:2]]] <=
                        m_we[k] ? m_wdata[k] : m_addr[k];
                    m_rdata[k] <= m_we[k] ? m_wdata[k] : m_addr[k];
                    lru_m[k][m_addr[k][5:2]] <= ~lru_m[k][m_addr[k][5:2]];
                end
            end
        end
    end

    // One transaction on instance d, port p. Cycle 0 is the accept cycle;
    // observations are taken 1 time unit after each falling edge.
    task automatic run_txn(input int d, input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [1:0] rdy, output int rcyc,
                           output logic [1:0] rvld, output logic hit, output logic [31:0] rdata,
                           output int re_mask, output int we_mask, output logic [31:0] caddr,
                           output logic [31:0] cwdata);
        @(negedge clk);
        req_valid[d][p] = 1'b1;
        req_we[d][p]    = we;
        req_addr[d][32*p +: 32]  = addr;
        req_wdata[d][32*p +: 32] = wdata;
        #1 rdy = req_ready[d];
        rcyc = -1; rvld = '0; hit = 1'b0; rdata = '0;
        re_mask = 0; we_mask = 0; caddr = '0; cwdata = '0;
        for (int c = 1; c <= 20 && rcyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[d][p] = 1'b0;
            #1;
            if (m_re[d]) re_mask |= (1 << c);
            if (m_we[d]) we_mask |= (1 << c);
            if (c == 1) begin caddr = m_addr[d]; cwdata = m_wdata[d]; end
            if (rsp_valid[d] != 2'b00) begin
                rcyc = c; rvld = rsp_valid[d]; hit = rsp_hit[d]; rdata = rsp_rdata[d];
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] obs2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({busy[0], m_re[0], m_we[0], rsp_hit[0]} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {busy[0], m_re[0], m_we[0], rsp_hit[0]});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        obs2 = req_ready[0];
        n_total++;
        if (obs2 !== 2'b00) $display("FAIL reset_ready: got %b want 00", obs2); else n_pass++;
        n_total++;
        if (rsp_valid[0] !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid[0]);
        else n_pass++;
        n_total++;
        if ({hit_cnt[0], miss_cnt[0]} !== 64'h0)
            $display("FAIL reset_counters: got %h/%h want 0/0", hit_cnt[0], miss_cnt[0]);
        else n_pass++;
        n_total++;
        if ({m_addr[0], m_wdata[0], rsp_rdata[0]} !== 96'h0)
            $display("FAIL reset_datapath: got %h %h %h want 0", m_addr[0], m_wdata[0], rsp_rdata[0]);
        else n_pass++;
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy[0]); else n_pass++;
    endtask

    task automatic test_write_read();
        logic [1:0] rdy, rvld; int rcyc, rem, wem; logic hit; logic [31:0] rdata, ca, cw;
        run_txn(0, 0, 1'b1, 32'h40, 32'hDEAD_BEEF, rdy, rcyc, rvld, hit, rdata, rem, wem, ca, cw);
        n_total++;
        if (rdy !== 2'b01) $display("FAIL wr_ready: got %b want 01", rdy); else n_pass++;
        n_total++;
        if (rcyc !== 6) $display("FAIL wr_latency: got %0d want 6", rcyc); else n_pass++;
        n_total++;
        if ({rvld, hit, rdata} !== {2'b01, 1'b0, 32'h0})
            $display("FAIL wr_resp: got v=%b hit=%b d=%h want v=01 hit=0 d=0", rvld, hit, rdata);
        else n_pass++;
        n_total++;
        if (wem !== 2 || rem !== 0)
            $display("FAIL wr_enables: got we_mask=%0h re_mask=%0h want 2/0", wem, rem);
        else n_pass++;
        n_total++;
        if (ca !== 32'h40 || cw !== 32'hDEAD_BEEF)
            $display("FAIL wr_cache_bus: got %h/%h want 40/deadbeef", ca, cw);
        else n_pass++;
        run_txn(0, 0, 1'b0, 32'h40, 32'h0, rdy, rcyc, rvld, hit, rdata, rem, wem, ca, cw);
        n_total++;
        if (rcyc !== 2) $display("FAIL rd_hit_latency: got %0d want 2", rcyc); else n_pass++;
        n_total++;
        if ({rvld, hit, rdata} !== {2'b01, 1'b1, 32'hDEAD_BEEF})
            $display("FAIL rd_hit_resp: got v=%b hit=%b d=%h want v=01 hit=1 d=deadbeef",
                     rvld, hit, rdata);
        else n_pass++;
        n_total++;
        if (hit_cnt[0] !== 32'd1 || miss_cnt[0] !== 32'd1)
            $display("FAIL counts_1: got %0d/%0d want 1/1", hit_cnt[0], miss_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_read_miss();
        logic [1:0] rdy, rvld; int rcyc, rem, wem; logic hit; logic [31:0] rdata, ca, cw;
        run_txn(0, 1, 1'b0, 32'h104, 32'h0, rdy, rcyc, rvld, hit, rdata, rem, wem, ca, cw);
        n_total++;
        if (rdy !== 2'b10) $display("FAIL rm_ready: got %b want 10", rdy); else n_pass++;
        n_total++;
        if (rem !== ((1 << 1) | (1 << 6)) || wem !== 0)
            $display("FAIL rm_read_en: got re_mask=%0h we_mask=%0h want 42/0", rem, wem);
        else n_pass++;
        n_total++;
        if (rcyc !== 7) $display("FAIL rm_latency: got %0d want 7", rcyc); else n_pass++;
        n_total++;
        if ({rvld, hit, rdata} !== {2'b10, 1'b0, 32'h104})
            $display("FAIL rm_resp: got v=%b hit=%b d=%h want v=10 hit=0 d=104", rvld, hit, rdata);
        else n_pass++;
        n_total++;
        if (hit_cnt[0] !== 32'd1 || miss_cnt[0] !== 32'd2)
            $display("FAIL counts_2: got %0d/%0d want 1/2", hit_cnt[0], miss_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] gnt [8]; logic [1:0] rsv [8]; logic [31:0] rdt [8];
        int gcyc [8]; int ng, nr, bad_pulse; logic [1:0] prev;
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        ng = 0; nr = 0; bad_pulse = 0; prev = '0;
        @(negedge clk);
        req_valid[0] = 2'b11; req_we[0] = 2'b00;
        req_addr[0]  = {32'h40, 32'h40};
        for (int c = 0; c < 40 && nr < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (ng >= 4) req_valid[0] = 2'b00;
            #1;
            if (req_ready[0] != 2'b00) begin
                if (ng < 8) begin gnt[ng] = req_ready[0]; gcyc[ng] = c; end
                ng++;
                if (prev != 2'b00) bad_pulse++;
            end
            prev = req_ready[0];
            if (rsp_valid[0] != 2'b00 && nr < 8) begin
                rsv[nr] = rsp_valid[0]; rdt[nr] = rsp_rdata[0]; nr++;
            end
        end
        req_valid[0] = 2'b00;
        n_total++;
        if (ng !== 4 || nr !== 4) $display("FAIL b2b_count: got %0d grants %0d rsps want 4/4", ng, nr);
        else n_pass++;
        n_total++;
        if (bad_pulse !== 0) $display("FAIL b2b_pulse: got %0d wide pulses want 0", bad_pulse);
        else n_pass++;
        for (int i = 0; i < 4 && i < ng && i < nr; i++) begin
            n_total++;
            if (gnt[i] !== exp_g[i] || rsv[i] !== exp_g[i] || rdt[i] !== 32'hDEAD_BEEF)
                $display("FAIL b2b_txn%0d: got g=%b r=%b d=%h want g=r=%b d=deadbeef",
                         i, gnt[i], rsv[i], rdt[i], exp_g[i]);
            else n_pass++;
        end
        if (ng >= 4) begin
            n_total++;
            if (gcyc[3] - gcyc[0] !== 9)
                $display("FAIL b2b_spacing: got %0d cycles want 9", gcyc[3] - gcyc[0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_stall();
        int seen_rsp, rcyc; logic [1:0] rdy, rvld; logic hit; logic [31:0] rdata;
        seen_rsp = 0;
        @(negedge clk);
        req_valid[0][0] = 1'b1; req_we[0][0] = 1'b0; req_addr[0][31:0] = 32'h208;
        @(negedge clk);
        req_valid[0][0] = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (busy[0] !== 1'b1) $display("FAIL rs_busy_pre: got %b want 1", busy[0]); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy[0], m_re[0], m_we[0]} !== 3'b000)
            $display("FAIL rs_async: got %b want 000", {busy[0], m_re[0], m_we[0]});
        else n_pass++;
        repeat (2) begin @(negedge clk); #1; if (rsp_valid[0] != 2'b00) seen_rsp++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); #1; if (rsp_valid[0] != 2'b00) seen_rsp++; end
        n_total++;
        if (seen_rsp !== 0) $display("FAIL rs_dropped: got %0d responses want 0", seen_rsp);
        else n_pass++;
        @(negedge clk);
        req_valid[0] = 2'b11; req_we[0] = 2'b00;
        req_addr[0]  = {32'h104, 32'h208};
        #1 rdy = req_ready[0];
        n_total++;
        if (rdy !== 2'b01) $display("FAIL rs_priority: got %b want 01", rdy); else n_pass++;
        rcyc = -1; rvld = '0; hit = 1'b0; rdata = '0;
        for (int c = 1; c <= 12 && rcyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[0] = 2'b00;
            #1;
            if (rsp_valid[0] != 2'b00) begin
                rcyc = c; rvld = rsp_valid[0]; hit = rsp_hit[0]; rdata = rsp_rdata[0];
            end
        end
        n_total++;
        if (rcyc !== 2 || {rvld, hit, rdata} !== {2'b01, 1'b1, 32'h208})
            $display("FAIL rs_fill_kept: got cyc=%0d v=%b hit=%b d=%h want 2 01 1 208",
                     rcyc, rvld, hit, rdata);
        else n_pass++;
        n_total++;
        if (hit_cnt[0] !== 32'd1 || miss_cnt[0] !== 32'd0)
            $display("FAIL rs_counts: got %0d/%0d want 1/0", hit_cnt[0], miss_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        logic [1:0] rdy, rvld; int rcyc, rem, wem; logic hit; logic [31:0] rdata, ca, cw;
        @(negedge clk);
        force u_dut0.hit_count_q = 32'hFFFF_FFFF;
        #1 release u_dut0.hit_count_q;
        run_txn(0, 0, 1'b0, 32'h40, 32'h0, rdy, rcyc, rvld, hit, rdata, rem, wem, ca, cw);
        n_total++;
        if (hit !== 1'b1 || rcyc !== 2) $display("FAIL wrap_hit: got hit=%b cyc=%0d want 1/2", hit, rcyc);
        else n_pass++;
        n_total++;
        if (hit_cnt[0] !== 32'h0) $display("FAIL wrap_count: got %h want 00000000", hit_cnt[0]);
        else n_pass++;
        n_total++;
        if (miss_cnt[0] !== 32'h0) $display("FAIL wrap_miss: got %h want 00000000", miss_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_min_latency();
        logic [1:0] rdy, rvld; int rcyc, rem, wem; logic hit; logic [31:0] rdata, ca, cw;
        run_txn(1, 0, 1'b0, 32'h300, 32'h0, rdy, rcyc, rvld, hit, rdata, rem, wem, ca, cw);
        n_total++;
        if (rcyc !== 4) $display("FAIL ml1_rd_latency: got %0d want 4", rcyc); else n_pass++;
        n_total++;
        if (rem !== ((1 << 1) | (1 << 3)))
            $display("FAIL ml1_read_en: got %0h want a", rem);
        else n_pass++;
        n_total++;
        if ({rvld, hit, rdata} !== {2'b01, 1'b0, 32'h300})
            $display("FAIL ml1_rd_resp: got v=%b hit=%b d=%h want 01 0 300", rvld, hit, rdata);
        else n_pass++;
        run_txn(1, 0, 1'b1, 32'h340, 32'h1234_5678, rdy, rcyc, rvld, hit, rdata, rem, wem, ca, cw);
        n_total++;
        if (rcyc !== 3 || hit !== 1'b0 || rdata !== 32'h0)
            $display("FAIL ml1_wr_miss: got cyc=%0d hit=%b d=%h want 3 0 0", rcyc, hit, rdata);
        else n_pass++;
        n_total++;
        if (hit_cnt[1] !== 32'd0 || miss_cnt[1] !== 32'd2)
            $display("FAIL ml1_counts: got %0d/%0d want 0/2", hit_cnt[1], miss_cnt[1]);
        else n_pass++;
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_read_miss();
        test_back_to_back();
        test_reset_in_stall();
        test_counter_wrap();
        test_min_latency();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
